psum_accum_wb: RTL and testbench

- Receiving end of the PE array's partial-sum stream, driven by the PE sequencer's `p_valid_output` / `last_chanel_output` / `end_conv`.
- Accumulates per-lane partial sums across input-channel passes of one output tile, using a local TILE_LEN-entry accumulator.
- On the last-channel pass it saturates each result, writes it into a small output FIFO, and presents it on a valid/ready write port toward the OFM buffer.
- Signals tile completion and end-of-convolution after the FIFO drains.

---
 rtl/psum_accum_wb.sv | 201 ++++++++++++++++++++
 tb/tb_psum_accum_wb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_wb.sv
// Partial-sum accumulator and write-back FIFO for the PE array output stream.
// Optional macro PSUM_RELU_EN clamps negative saturated results to zero.
module psum_accum_wb #(
    parameter int LANES      = 8,
    parameter int PSUM_W     = 20,
    parameter int ACC_W      = 28,
    parameter int OUT_W      = 8,
    parameter int TILE_LEN   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TILE_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        p_valid,
    input  logic                        last_chanel,
    input  logic                        end_conv,
    input  logic [LANES*PSUM_W-1:0]     psum_in,
    output logic                        ofm_valid,
    input  logic                        ofm_ready,
    output logic [LANES*OUT_W-1:0]      ofm_data,
    output logic [$clog2(TILE_LEN)-1:0] ofm_idx,
    output logic [TILE_W-1:0]           ofm_tile,
    output logic                        tile_done,
    output logic                        done,
    output logic                        busy,
    output logic                        ovf_err
);

    localparam int IDX_W = $clog2(TILE_LEN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DAT_W = LANES * OUT_W;
    localparam int E_W   = DAT_W + IDX_W + TILE_W;

    localparam logic signed [ACC_W-1:0] SAT_HI =
        ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0]       r_idx;
    logic                   r_first;
    logic [TILE_W-1:0]      r_tile;
    logic                   r_tile_done;
    logic                   r_ovf;
    logic [LANES*ACC_W-1:0] r_acc [TILE_LEN];

    logic [E_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_cnt;

    logic                   w_beat;
    logic                   w_wrap;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_push_ok;
    logic [LANES*ACC_W-1:0] w_acc_rd;
    logic [LANES*ACC_W-1:0] w_sum_all;
    logic [DAT_W-1:0]       w_sat_all;
    logic [E_W-1:0]         w_head;

    assign w_beat   = (r_state == S_RUN) && p_valid && !start;
    assign w_wrap   = (r_idx == IDX_W'(TILE_LEN - 1));
    assign w_acc_rd = r_acc[r_idx];

    // first_pass masks stale accumulator contents
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [ACC_W-1:0] w_ext;
        logic signed [ACC_W-1:0] w_prev;
        logic signed [ACC_W-1:0] w_sum;
        logic [OUT_W-1:0]        w_sat;

        assign w_ext  = ACC_W'($signed(psum_in[g*PSUM_W +: PSUM_W]));
        assign w_prev = r_first ? '0 : w_acc_rd[g*ACC_W +: ACC_W];
        assign w_sum  = w_prev + w_ext;

        always_comb begin
            if (w_sum > SAT_HI) begin
                w_sat = SAT_HI[OUT_W-1:0];
            end else if (w_sum < SAT_LO) begin
                w_sat = SAT_LO[OUT_W-1:0];
            end else begin
                w_sat = w_sum[OUT_W-1:0];
            end
`ifdef PSUM_RELU_EN
            if (w_sat[OUT_W-1]) begin
                w_sat = '0;
            end
`endif
        end

        assign w_sum_all[g*ACC_W +: ACC_W] = w_sum;
        assign w_sat_all[g*OUT_W +: OUT_W] = w_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_RUN;
        end else begin
            unique case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_RUN:   if (end_conv) w_next = S_DRAIN;
                S_DRAIN: if (w_empty) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DRAIN) && w_empty;
    end

    always_ff @(posedge clk) begin
        if (w_beat && !last_chanel) begin
            r_acc[r_idx] <= w_sum_all;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_idx       <= '0;
            r_first     <= 1'b1;
            r_tile      <= '0;
            r_tile_done <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_tile_done <= w_beat && last_chanel && w_wrap;
            if (w_beat) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
                if (w_wrap) begin
                    r_first <= last_chanel;
                    if (last_chanel) begin
                        r_tile <= r_tile + 1'b1;
                    end
                end
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign w_pop   = !w_empty && ofm_ready;
    assign w_push  = w_beat && last_chanel;
    // a same-cycle pop frees the slot for a push into a full FIFO
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wp] <= {w_sat_all, r_idx, r_tile};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop)     r_rp <= r_rp + 1'b1;
            unique case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign w_head    = r_mem[r_rp];
    assign ofm_valid = !w_empty;
    assign ofm_data  = ofm_valid ? w_head[E_W-1 -: DAT_W] : '0;
    assign ofm_idx   = ofm_valid ? w_head[IDX_W+TILE_W-1 -: IDX_W] : '0;
    assign ofm_tile  = ofm_valid ? w_head[TILE_W-1:0] : '0;
    assign tile_done = r_tile_done;
    assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_psum_accum_wb.sv
// Self-checking bench for psum_accum_wb: vector table, directed
// sequences and randomized traffic against a queue-based reference model.
module tb_psum_accum_wb;

    localparam int L  = 8;
    localparam int PW = 20;
    localparam int TL = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          p_valid = 1'b0;
    logic          last_chanel = 1'b0;
    logic          end_conv = 1'b0;
    logic [L*PW-1:0] psum_in = '0;
    logic          ofm_valid;
    logic          ofm_ready = 1'b0;
    logic [L*8-1:0] ofm_data;
    logic [3:0]    ofm_idx;
    logic [7:0]    ofm_tile;
    logic          tile_done;
    logic          done;
    logic          busy;
    logic          ovf_err;

    psum_accum_wb dut (
        .clk(clk), .rst(rst), .start(start),
        .p_valid(p_valid), .last_chanel(last_chanel),
        .end_conv(end_conv), .psum_in(psum_in),
        .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
        .ofm_data(ofm_data), .ofm_idx(ofm_idx),
        .ofm_tile(ofm_tile), .tile_done(tile_done),
        .done(done), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int fo(input int v);
`ifdef PSUM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [63:0] rep(input int v);
        logic [63:0] d;
        logic [7:0]  b;
        b = 8'(v);
        for (int l = 0; l < L; l++) d[l*8 +: 8] = b;
        return d;
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN} mst_t;
    typedef struct {
        logic [63:0] data;
        int          idx;
        int          tile;
    } ent_t;

    mst_t   m_st;
    longint m_acc [TL][L];
    bit     m_first;
    int     m_idx;
    int     m_tile;
    bit     m_td;
    bit     m_ovf;
    ent_t   m_q[$];

    function automatic int msat(input longint s);
        logic signed [27:0] t;
        longint w;
        t = s[27:0];
        w = t;
        if (w > 127) w = 127;
        if (w < -128) w = -128;
        return fo(int'(w));
    endfunction

    function automatic longint lane_in(input int l);
        logic signed [PW-1:0] p;
        p = psum_in[l*PW +: PW];
        return longint'(p);
    endfunction

    task automatic m_clear();
        m_idx = 0; m_first = 1; m_tile = 0;
        m_td = 0; m_ovf = 0; m_q.delete();
    endtask

    task automatic model_update();
        bit   pre_empty;
        ent_t e;
        if (rst) begin
            m_st = M_IDLE; m_clear(); return;
        end
        if (start) begin
            m_st = M_RUN; m_clear(); return;
        end
        pre_empty = (m_q.size() == 0);
        m_td = 0;
        if (!pre_empty && ofm_ready) void'(m_q.pop_front());
        if (m_st == M_RUN && p_valid) begin
            e.idx = m_idx; e.tile = m_tile; e.data = '0;
            for (int l = 0; l < L; l++) begin
                longint s;
                logic signed [27:0] t;
                logic [7:0] b;
                s = (m_first ? 0 : m_acc[m_idx][l]) + lane_in(l);
                t = s[27:0];
                b = 8'(msat(s));
                if (last_chanel) e.data[l*8 +: 8] = b;
                else m_acc[m_idx][l] = longint'(t);
            end
            if (last_chanel) begin
                if (m_q.size() < FD) m_q.push_back(e);
                else m_ovf = 1;
            end
            if (m_idx == TL - 1) begin
                m_idx = 0;
                if (last_chanel) begin
                    m_first = 1; m_td = 1;
                    m_tile = (m_tile + 1) % 256;
                end else begin
                    m_first = 0;
                end
            end else begin
                m_idx++;
            end
        end
        if (m_st == M_RUN && end_conv) m_st = M_DRAIN;
        else if (m_st == M_DRAIN && pre_empty) m_st = M_IDLE;
    endtask

    task automatic check_model();
        bit v;
        v = (m_q.size() != 0);
        chk("m_valid", 64'(ofm_valid), 64'(v));
        chk("m_data", ofm_data, v ? m_q[0].data : 64'd0);
        chk("m_idx", 64'(ofm_idx), v ? 64'(m_q[0].idx) : 64'd0);
        chk("m_tile", 64'(ofm_tile), v ? 64'(m_q[0].tile) : 64'd0);
        chk("m_tile_done", 64'(tile_done), 64'(m_td));
        chk("m_done", 64'(done),
            64'(m_st == M_DRAIN && m_q.size() == 0));
        chk("m_busy", 64'(busy), 64'(m_st != M_IDLE));
        chk("m_ovf", 64'(ovf_err), 64'(m_ovf));
    endtask

    // ---------------- stimulus helpers ----------------
    ent_t cap[$];
    int   n_td;
    int   n_done;

    task automatic tick();
        ent_t e;
        if (ofm_valid && ofm_ready) begin
            e.data = ofm_data; e.idx = ofm_idx; e.tile = ofm_tile;
            cap.push_back(e);
        end
        @(posedge clk);
        model_update();
        #1;
        check_model();
        if (tile_done) n_td++;
        if (done) n_done++;
    endtask

    task automatic set_all(input int v);
        for (int l = 0; l < L; l++) psum_in[l*PW +: PW] = PW'(v);
    endtask

    task automatic idle_in();
        start = 0; p_valid = 0; last_chanel = 0; end_conv = 0;
    endtask

    task automatic do_reset();
        idle_in(); rst = 1; tick(); rst = 0;
    endtask

    task automatic do_start();
        idle_in(); start = 1; tick(); start = 0;
        cap.delete(); n_td = 0; n_done = 0;
    endtask

    task automatic beat(input int v, input bit lc);
        set_all(v); p_valid = 1; last_chanel = lc; tick();
        p_valid = 0; last_chanel = 0;
    endtask

    task automatic pass(input int v, input bit lc);
        for (int i = 0; i < TL; i++) beat(v, lc);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_caps(input string nm, input int n, input int v);
        chk({nm, "_count"}, 64'(cap.size()), 64'(n));
        foreach (cap[i]) begin
            chk({nm, "_data"}, cap[i].data, rep(fo(v)));
            chk({nm, "_idx"}, 64'(cap[i].idx), 64'(i % TL));
        end
    endtask

    typedef struct {
        bit st, pv, lc, ec, rdy;
        int ps;
        bit e_valid;
        int e_lane;
        int e_idx;
        bit e_done, e_busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1,0,0,0,0, 0, 0, 0,0, 0,1};
        tbl[1] = '{0,1,1,0,0, 5, 1, 5,0, 0,1};
        tbl[2] = '{0,1,1,0,0,-3, 1, 5,0, 0,1};
        tbl[3] = '{0,0,0,1,0, 0, 1, 5,0, 0,1};
        tbl[4] = '{0,0,0,0,1, 0, 1,-3,1, 0,1};
        tbl[5] = '{0,0,0,0,1, 0, 0, 0,0, 1,1};
        tbl[6] = '{0,0,0,0,1, 0, 0, 0,0, 0,0};
        tbl[7] = '{0,1,1,0,1, 9, 0, 0,0, 0,0};

        do_reset();
        chk("rst_valid", 64'(ofm_valid), 0);
        chk("rst_data", ofm_data, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ovf", 64'(ovf_err), 0);
        chk("rst_td", 64'(tile_done), 0);

        foreach (tbl[i]) begin
            start = tbl[i].st; p_valid = tbl[i].pv;
            last_chanel = tbl[i].lc; end_conv = tbl[i].ec;
            ofm_ready = tbl[i].rdy; set_all(tbl[i].ps);
            tick();
            chk("tbl_valid", 64'(ofm_valid), 64'(tbl[i].e_valid));
            chk("tbl_data", ofm_data,
                tbl[i].e_valid ? rep(fo(tbl[i].e_lane)) : 64'd0);
            chk("tbl_idx", 64'(ofm_idx), 64'(tbl[i].e_idx));
            chk("tbl_tile", 64'(ofm_tile), 0);
            chk("tbl_done", 64'(done), 64'(tbl[i].e_done));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
        end
        idle_in();

        // single pass: lane values idx-8
        ofm_ready = 1;
        do_start();
        for (int i = 0; i < TL; i++) beat(i - 8, 1);
        idle_ticks(4);
        chk("sp_count", 64'(cap.size()), TL);
        foreach (cap[i]) begin
            chk("sp_data", cap[i].data, rep(fo(i - 8)));
            chk("sp_idx", 64'(cap[i].idx), 64'(i));
            chk("sp_tile", 64'(cap[i].tile), 0);
        end
        chk("sp_tile_done", 64'(n_td), 1);

        // two-pass accumulation and saturation
        do_start(); pass(100, 0); pass(27, 1); idle_ticks(3);
        chk_caps("tp127", TL, 127);
        do_start(); pass(100, 0); pass(28, 1); idle_ticks(3);
        chk_caps("tp128", TL, 127);
        do_start(); pass(-200, 0); pass(-10, 1); idle_ticks(3);
        chk_caps("tpneg", TL, -128);

        // backpressure: 4 held, overflow from the 5th beat
        do_start();
        ofm_ready = 0;
        for (int i = 0; i < TL; i++) begin
            beat(i, 1);
            if (i == 3) chk("bp_ovf4", 64'(ovf_err), 0);
            if (i == 4) chk("bp_ovf5", 64'(ovf_err), 1);
        end
        ofm_ready = 1;
        idle_ticks(6);
        chk("bp_count", 64'(cap.size()), FD);
        foreach (cap[i]) begin
            chk("bp_idx", 64'(cap[i].idx), 64'(i));
            chk("bp_data", cap[i].data, rep(fo(i)));
        end

        // full FIFO with a pop on the push cycle
        do_start();
        ofm_ready = 0;
        for (int i = 0; i < FD; i++) beat(i + 1, 1);
        ofm_ready = 1;
        beat(FD + 1, 1);
        chk("fp_ovf", 64'(ovf_err), 0);
        idle_ticks(6);
        chk("fp_count", 64'(cap.size()), FD + 1);

        // end_conv with 2 pending entries
        do_start();
        ofm_ready = 0;
        beat(3, 1); beat(4, 1);
        end_conv = 1; tick(); end_conv = 0;
        chk("ec_busy", 64'(busy), 1);
        ofm_ready = 1;
        idle_ticks(8);
        chk("ec_done_once", 64'(n_done), 1);
        chk("ec_idle", 64'(busy), 0);
        beat(7, 1);
        chk("ec_nopush", 64'(ofm_valid), 0);

        // start mid-pass flushes FIFO and resets first_pass/idx
        do_start();
        ofm_ready = 0;
        pass(50, 0);
        for (int i = 0; i < 7; i++) beat(50, 1);
        do_start();
        chk("ms_flush", 64'(ofm_valid), 0);
        chk("ms_ovf", 64'(ovf_err), 0);
        ofm_ready = 1;
        pass(1, 1);
        idle_ticks(3);
        chk_caps("ms", TL, 1);

        // rst mid-run
        do_start();
        ofm_ready = 0;
        beat(2, 1); beat(2, 1);
        do_reset();
        chk("mr_valid", 64'(ofm_valid), 0);
        chk("mr_data", ofm_data, 0);
        chk("mr_busy", 64'(busy), 0);

        // randomized traffic
        for (int c = 0; c < 20; c++) begin
            int np;
            do_start();
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                int nb;
                nb = 0;
                while (nb < TL) begin
                    p_valid = ($urandom % 4) != 0;
                    last_chanel = (p == np - 1) ? 1'b1 : 1'b0;
                    ofm_ready = ($urandom % 3) != 0;
                    for (int l = 0; l < L; l++) begin
                        if ($urandom % 2)
                            psum_in[l*PW +: PW] = PW'($urandom);
                        else
                            psum_in[l*PW +: PW] =
                                PW'(int'($urandom_range(0, 80)) - 40);
                    end
                    if (p_valid) nb++;
                    tick();
                end
            end
            idle_in();
            end_conv = 1; tick(); end_conv = 0;
            for (int k = 0; k < 64 && busy; k++) begin
                ofm_ready = ($urandom % 3) != 0;
                tick();
            end
            chk("rnd_drain", 64'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
